// File: rtl/e_longop_pkg.sv
// Shared definitions for the execute-stage long-op retire queue.
// Unit index constants and width helpers used to size pointers and unit-index fields.
// Entry layouts are declared inside the modules because their widths depend on module parameters.
package e_longop_pkg;

  // Fixed unit slots: index 0 is the extended ALU (mul/div), index 1 the shift/count ALU.
  localparam int UNIT_XALU = 0;
  localparam int UNIT_SALU = 1;

  // Pointer width: entry index plus one wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Unit-index width, never below one bit so single-unit builds still have a legal field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/e_longop_slot.sv
// One parked entry of the long-op retire queue: written at issue, captures its unit's result, freed at retire.
// Latency: a write, capture or invalidate is visible one cycle after the requesting edge.
// Backpressure: none locally; the top only writes a free slot and only invalidates the head.
//
// Ports:
//   Clk, reset             clock and synchronous active-high reset
//   clear_i                flush: drop the entry
//   wr_i/wr_unit_i/wr_payload_i  issue write into this (free) slot
//   unit_done_i/unit_result_i    completion pulses and results of all units
//   inv_i                  retire of this slot (wins over a same-cycle capture)
//   valid_o/unit_o/done_o/result_o/payload_o  stored entry
//   wait_o                 entry is valid and still waiting for its unit
module e_longop_slot
  import e_longop_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  parameter int PAYLOAD_W = 160,
  parameter int DATA_W    = 32
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic                          clear_i,
  input  logic                          wr_i,
  input  logic [idx_w(NUM_UNITS)-1:0]   wr_unit_i,
  input  logic [PAYLOAD_W-1:0]          wr_payload_i,
  input  logic [NUM_UNITS-1:0]          unit_done_i,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_result_i,
  input  logic                          inv_i,
  output logic                          valid_o,
  output logic [idx_w(NUM_UNITS)-1:0]   unit_o,
  output logic                          done_o,
  output logic [DATA_W-1:0]             result_o,
  output logic [PAYLOAD_W-1:0]          payload_o,
  output logic                          wait_o
);

  localparam int UNIT_W = idx_w(NUM_UNITS);

  typedef struct packed {
    logic                 valid;
    logic [UNIT_W-1:0]    unit;
    logic                 done;
    logic [DATA_W-1:0]    result;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t ent_q, ent_d;

  logic              sel_done;
  logic [DATA_W-1:0] sel_result;

  // Pick out the completion lane of the unit this entry is parked on.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (ent_q.unit == UNIT_W'(u)) begin
        sel_done   = unit_done_i[u];
        sel_result = unit_result_i[u*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    if (clear_i) begin
      ent_d = '0;
    end else if (inv_i) begin
      // Retire may consume a same-cycle completion through the bypass; nothing left to capture.
      ent_d.valid = 1'b0;
      ent_d.done  = 1'b0;
    end else if (wr_i) begin
      ent_d.valid   = 1'b1;
      ent_d.unit    = wr_unit_i;
      ent_d.payload = wr_payload_i;
      ent_d.done    = 1'b0;
      ent_d.result  = '0;
    end else if (ent_q.valid && !ent_q.done && sel_done) begin
      ent_d.done   = 1'b1;
      ent_d.result = sel_result;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign valid_o   = ent_q.valid;
  assign unit_o    = ent_q.unit;
  assign done_o    = ent_q.done;
  assign result_o  = ent_q.result;
  assign payload_o = ent_q.payload;
  assign wait_o    = ent_q.valid && !ent_q.done;

endmodule

// File: rtl/e_longop_retire_queue.sv
// Parks long-latency execute ops while their non-pipelined units compute; retires them in issue order to E/M.
// Latency: a done pulse on the head entry produces retire_valid_o after the next edge (result bypassed).
// Backpressure: issue_ready_o drops when full or the target unit is busy; retire_stall_i freezes the retire registers.
//
// Ports:
//   Clk, reset                          clock, synchronous active-high reset
//   flush_i                             exception flush, drops every entry and the retire registers
//   issue_valid_i/unit_i/payload_i      issue request from decode
//   issue_ready_o                       request is accepted this cycle when issue_valid_i is high
//   unit_start_o                        one-hot start to the unit, in the accept cycle
//   unit_done_i/unit_result_i           per-unit completion pulse and result
//   retire_stall_i                      memory-stage stall
//   retire_valid_o/payload_o/data_o     registered retire outputs
//   busy_o/count_o/unit_pending_o       occupancy for hazard logic
//   err_o                               sticky: completion with no waiting entry
module e_longop_retire_queue
  import e_longop_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 160,
  parameter int DATA_W    = 32
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  input  logic [idx_w(NUM_UNITS)-1:0]   issue_unit_i,
  input  logic [PAYLOAD_W-1:0]          issue_payload_i,
  output logic                          issue_ready_o,
  output logic [NUM_UNITS-1:0]          unit_start_o,
  input  logic [NUM_UNITS-1:0]          unit_done_i,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_result_i,
  input  logic                          retire_stall_i,
  output logic                          retire_valid_o,
  output logic [PAYLOAD_W-1:0]          retire_payload_o,
  output logic [DATA_W-1:0]             retire_data_o,
  output logic                          busy_o,
  output logic [ptr_w(DEPTH)-1:0]       count_o,
  output logic [NUM_UNITS-1:0]          unit_pending_o,
  output logic                          err_o
);

  localparam int UNIT_W = idx_w(NUM_UNITS);
  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int IDX_W  = PTR_W - 1;
  localparam logic [UNIT_W:0] UNIT_LIM = (UNIT_W + 1)'(NUM_UNITS);

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic                 retire_valid_q, retire_valid_d;
  logic [PAYLOAD_W-1:0] retire_payload_q, retire_payload_d;
  logic [DATA_W-1:0]    retire_data_q, retire_data_d;
  logic                 err_q, err_d;

  logic [DEPTH-1:0]     slot_valid, slot_done, slot_wait, slot_wr, slot_inv;
  logic [UNIT_W-1:0]    slot_unit    [DEPTH];
  logic [DATA_W-1:0]    slot_result  [DEPTH];
  logic [PAYLOAD_W-1:0] slot_payload [DEPTH];

  logic [IDX_W-1:0]     head_idx, tail_idx;
  logic                 full, unit_ok, accept;
  logic [UNIT_W-1:0]    head_unit;
  logic                 head_bypass, head_ready, retire_fire;
  logic [DATA_W-1:0]    bypass_data, head_data;
  logic [NUM_UNITS-1:0] unit_waiting;
  logic                 stray_done;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_q[PTR_W-1] != tail_q[PTR_W-1]) && (head_idx == tail_idx);

  // Full is judged on registered pointers, so a same-cycle retire never frees a slot for issue.
  assign unit_ok       = {1'b0, issue_unit_i} < UNIT_LIM;
  assign issue_ready_o = !reset && !flush_i && !full && unit_ok && !pending_q[issue_unit_i];
  assign accept        = issue_valid_i && issue_ready_o;

  always_comb begin
    unit_start_o = '0;
    if (accept) begin
      unit_start_o[issue_unit_i] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_wr[gi]  = accept && (tail_idx == IDX_W'(gi));
      assign slot_inv[gi] = retire_fire && (head_idx == IDX_W'(gi));

      e_longop_slot #(
        .NUM_UNITS (NUM_UNITS),
        .PAYLOAD_W (PAYLOAD_W),
        .DATA_W    (DATA_W)
      ) u_slot (
        .Clk           (Clk),
        .reset         (reset),
        .clear_i       (flush_i),
        .wr_i          (slot_wr[gi]),
        .wr_unit_i     (issue_unit_i),
        .wr_payload_i  (issue_payload_i),
        .unit_done_i   (unit_done_i),
        .unit_result_i (unit_result_i),
        .inv_i         (slot_inv[gi]),
        .valid_o       (slot_valid[gi]),
        .unit_o        (slot_unit[gi]),
        .done_o        (slot_done[gi]),
        .result_o      (slot_result[gi]),
        .payload_o     (slot_payload[gi]),
        .wait_o        (slot_wait[gi])
      );
    end
  endgenerate

  // Head can retire on the same cycle its unit finishes, taking the result straight from the unit.
  assign head_unit = slot_unit[head_idx];

  always_comb begin
    head_bypass = 1'b0;
    bypass_data = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (head_unit == UNIT_W'(u)) begin
        head_bypass = unit_done_i[u];
        bypass_data = unit_result_i[u*DATA_W +: DATA_W];
      end
    end
  end

  assign head_ready  = slot_valid[head_idx] && (slot_done[head_idx] || head_bypass);
  assign head_data   = slot_done[head_idx] ? slot_result[head_idx] : bypass_data;
  assign retire_fire = head_ready && !retire_stall_i && !flush_i;

  // A done pulse is legal only if some entry for that unit is still waiting on it.
  always_comb begin
    unit_waiting = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (slot_wait[i] && (slot_unit[i] == UNIT_W'(u))) begin
          unit_waiting[u] = 1'b1;
        end
      end
    end
  end

  assign stray_done = |(unit_done_i & ~unit_waiting);

  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    pending_d        = pending_q;
    retire_valid_d   = retire_valid_q;
    retire_payload_d = retire_payload_q;
    retire_data_d    = retire_data_q;
    err_d            = err_q;
    if (flush_i) begin
      head_d           = '0;
      tail_d           = '0;
      pending_d        = '0;
      retire_valid_d   = 1'b0;
      retire_payload_d = '0;
      retire_data_d    = '0;
    end else begin
      if (accept) begin
        tail_d                  = tail_q + PTR_W'(1);
        pending_d[issue_unit_i] = 1'b1;
      end
      if (retire_fire) begin
        head_d               = head_q + PTR_W'(1);
        pending_d[head_unit] = 1'b0;
        retire_valid_d       = 1'b1;
        retire_payload_d     = slot_payload[head_idx];
        retire_data_d        = head_data;
      end else if (!retire_stall_i) begin
        retire_valid_d = 1'b0;
      end
      if (stray_done) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      pending_q        <= '0;
      retire_valid_q   <= 1'b0;
      retire_payload_q <= '0;
      retire_data_q    <= '0;
      err_q            <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      pending_q        <= pending_d;
      retire_valid_q   <= retire_valid_d;
      retire_payload_q <= retire_payload_d;
      retire_data_q    <= retire_data_d;
      err_q            <= err_d;
    end
  end

  assign retire_valid_o   = retire_valid_q;
  assign retire_payload_o = retire_payload_q;
  assign retire_data_o    = retire_data_q;
  assign count_o          = tail_q - head_q;
  assign busy_o           = (count_o != '0);
  assign unit_pending_o   = pending_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_e_longop_retire_queue.sv
// Self-checking bench for the long-op retire queue: directed scenarios plus randomized traffic vs a queue model.
module tb_e_longop_retire_queue;
  import e_longop_pkg::*;

  logic         Clk = 1'b0;
  logic         reset, flush, iv, stall;
  logic [0:0]   iu;
  logic [159:0] ip;
  logic [1:0]   ud;
  logic [63:0]  ur;

  logic         issue_ready_o, retire_valid_o, busy_o, err_o;
  logic [1:0]   unit_start_o, unit_pending_o, count_o;
  logic [159:0] retire_payload_o;
  logic [31:0]  retire_data_o;

  int vectors = 0;
  int miscompares = 0;

  e_longop_retire_queue dut (
    .Clk              (Clk),
    .reset            (reset),
    .flush_i          (flush),
    .issue_valid_i    (iv),
    .issue_unit_i     (iu),
    .issue_payload_i  (ip),
    .issue_ready_o    (issue_ready_o),
    .unit_start_o     (unit_start_o),
    .unit_done_i      (ud),
    .unit_result_i    (ur),
    .retire_stall_i   (stall),
    .retire_valid_o   (retire_valid_o),
    .retire_payload_o (retire_payload_o),
    .retire_data_o    (retire_data_o),
    .busy_o           (busy_o),
    .count_o          (count_o),
    .unit_pending_o   (unit_pending_o),
    .err_o            (err_o)
  );

  always #5 Clk = ~Clk;

  // Reference model: in-order list of parked ops, each waiting until its unit reports.
  typedef struct {
    int           unit;
    logic [159:0] payload;
    bit           done;
    logic [31:0]  result;
  } ment_t;

  ment_t        mq[$];
  bit           m_rv;
  logic [159:0] m_rp;
  logic [31:0]  m_rd;
  bit           m_err;

  function automatic bit m_pend(input int u);
    foreach (mq[i]) if (mq[i].unit == u) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_waiting(input int u);
    foreach (mq[i]) if (mq[i].unit == u && !mq[i].done) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return !reset && !flush && (mq.size() < 2) && !m_pend(int'(iu));
  endfunction

  function automatic logic [1:0] m_pend_mask();
    logic [1:0] m;
    m = 2'b00;
    for (int u = 0; u < 2; u++) m[u] = m_pend(u);
    return m;
  endfunction

  // Advance one clock and apply the same cycle's inputs to the model.
  task automatic tick();
    bit    acc;
    bit    hit;
    ment_t ne;
    acc = iv && m_ready();
    @(posedge Clk);
    if (reset) begin
      mq.delete(); m_rv = 0; m_rp = '0; m_rd = '0; m_err = 0;
    end else if (flush) begin
      mq.delete(); m_rv = 0; m_rp = '0; m_rd = '0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (ud[u]) begin
          hit = 0;
          foreach (mq[i]) begin
            if (!hit && mq[i].unit == u && !mq[i].done) begin
              mq[i].done = 1; mq[i].result = ur[u*32 +: 32]; hit = 1;
            end
          end
          if (!hit) m_err = 1;
        end
      end
      if (!stall) begin
        if (mq.size() > 0 && mq[0].done) begin
          m_rv = 1; m_rp = mq[0].payload; m_rd = mq[0].result;
          void'(mq.pop_front());
        end else begin
          m_rv = 0;
        end
      end
      if (acc) begin
        ne.unit = int'(iu); ne.payload = ip; ne.done = 0; ne.result = '0;
        mq.push_back(ne);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    iv = 0; iu = 1'b0; ip = '0; ud = 2'b00; ur = '0; stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; iv = 1; iu = 1'(UNIT_XALU);
    tick(); tick();
    #1;
    vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", issue_ready_o); end
    vectors++; if (unit_start_o !== 2'b00) begin miscompares++; $display("FAIL reset_start got=%b exp=00", unit_start_o); end
    vectors++; if (retire_valid_o !== 1'b0 || retire_payload_o !== 160'h0 || retire_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_retire got v=%b d=%h exp v=0 d=0", retire_valid_o, retire_data_o); end
    vectors++; if (count_o !== 2'd0 || busy_o !== 1'b0 || unit_pending_o !== 2'b00 || err_o !== 1'b0) begin miscompares++; $display("FAIL reset_state got cnt=%0d busy=%b pend=%b err=%b exp 0", count_o, busy_o, unit_pending_o, err_o); end
    reset = 0; iv = 0;
    tick();
  endtask

  task automatic test_basic();
    iv = 1; iu = 1'(UNIT_XALU); ip = 160'hA5;
    #1;
    vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL basic_ready got=%b exp=1", issue_ready_o); end
    vectors++; if (unit_start_o !== 2'b01) begin miscompares++; $display("FAIL basic_start got=%b exp=01", unit_start_o); end
    tick(); iv = 0;
    vectors++; if (count_o !== 2'd1 || unit_pending_o !== 2'b01 || busy_o !== 1'b1) begin miscompares++; $display("FAIL basic_parked got cnt=%0d pend=%b busy=%b exp 1/01/1", count_o, unit_pending_o, busy_o); end
    tick(); tick();
    ud = 2'b01; ur = {32'h0, 32'h12345678};
    tick(); ud = 2'b00;
    vectors++; if (retire_valid_o !== 1'b1 || retire_data_o !== 32'h12345678 || retire_payload_o !== 160'hA5) begin miscompares++; $display("FAIL basic_retire got v=%b d=%h p=%h exp v=1 d=12345678 p=a5", retire_valid_o, retire_data_o, retire_payload_o); end
    vectors++; if (count_o !== 2'd0 || unit_pending_o !== 2'b00) begin miscompares++; $display("FAIL basic_drain got cnt=%0d pend=%b exp 0/00", count_o, unit_pending_o); end
    tick();
    vectors++; if (retire_valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_bubble got=%b exp=0", retire_valid_o); end
  endtask

  task automatic test_order();
    iv = 1; iu = 1'(UNIT_XALU); ip = 160'h111; tick();
    iu = 1'(UNIT_SALU); ip = 160'h222; tick(); iv = 0;
    ud = 2'b10; ur = {32'hBBBB0002, 32'h0}; tick(); ud = 2'b00;
    vectors++; if (retire_valid_o !== 1'b0 || count_o !== 2'd2) begin miscompares++; $display("FAIL order_young_waits got v=%b cnt=%0d exp v=0 cnt=2", retire_valid_o, count_o); end
    tick();
    ud = 2'b01; ur = {32'h0, 32'hAAAA0001}; tick(); ud = 2'b00;
    vectors++; if (retire_valid_o !== 1'b1 || retire_payload_o !== 160'h111 || retire_data_o !== 32'hAAAA0001) begin miscompares++; $display("FAIL order_first got v=%b p=%h d=%h exp 1/111/aaaa0001", retire_valid_o, retire_payload_o, retire_data_o); end
    tick();
    vectors++; if (retire_valid_o !== 1'b1 || retire_payload_o !== 160'h222 || retire_data_o !== 32'hBBBB0002 || count_o !== 2'd0) begin miscompares++; $display("FAIL order_second got v=%b p=%h d=%h cnt=%0d exp 1/222/bbbb0002/0", retire_valid_o, retire_payload_o, retire_data_o, count_o); end
    tick();
  endtask

  task automatic test_full();
    iv = 1; iu = 1'(UNIT_XALU); ip = 160'hA0; tick();
    iu = 1'(UNIT_SALU); ip = 160'hB0; tick();
    iu = 1'(UNIT_XALU); ip = 160'hC0;
    #1;
    vectors++; if (issue_ready_o !== 1'b0 || unit_start_o !== 2'b00) begin miscompares++; $display("FAIL full_block got rdy=%b start=%b exp 0/00", issue_ready_o, unit_start_o); end
    tick();
    ud = 2'b01; ur = {32'h0, 32'h0000A0A0};
    #1;
    vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_same_cycle_retire got rdy=%b exp=0", issue_ready_o); end
    tick(); ud = 2'b00;
    vectors++; if (issue_ready_o !== 1'b1 || unit_start_o !== 2'b01 || count_o !== 2'd1) begin miscompares++; $display("FAIL full_reopen got rdy=%b start=%b cnt=%0d exp 1/01/1", issue_ready_o, unit_start_o, count_o); end
    tick(); iv = 0;
    vectors++; if (count_o !== 2'd2) begin miscompares++; $display("FAIL full_refill got cnt=%0d exp=2", count_o); end
    ud = 2'b11; ur = {32'h0000B0B0, 32'h0000C0C0}; tick(); ud = 2'b00;
    vectors++; if (retire_payload_o !== 160'hB0 || retire_data_o !== 32'h0000B0B0) begin miscompares++; $display("FAIL full_drain_b got p=%h d=%h exp b0/b0b0", retire_payload_o, retire_data_o); end
    tick();
    vectors++; if (retire_payload_o !== 160'hC0 || retire_data_o !== 32'h0000C0C0 || count_o !== 2'd0) begin miscompares++; $display("FAIL full_drain_c got p=%h d=%h cnt=%0d exp c0/c0c0/0", retire_payload_o, retire_data_o, count_o); end
    tick();
  endtask

  task automatic test_stall();
    iv = 1; iu = 1'(UNIT_XALU); ip = 160'h100; tick();
    iu = 1'(UNIT_SALU); ip = 160'h200; ud = 2'b01; ur = {32'h0, 32'h00000100}; tick();
    iv = 0; ud = 2'b10; ur = {32'h00000200, 32'h0}; stall = 1;
    for (int k = 0; k < 4; k++) begin
      tick(); ud = 2'b00;
      vectors++; if (retire_valid_o !== 1'b1 || retire_payload_o !== 160'h100 || retire_data_o !== 32'h00000100 || count_o !== 2'd1) begin miscompares++; $display("FAIL stall_hold[%0d] got v=%b p=%h d=%h cnt=%0d exp 1/100/100/1", k, retire_valid_o, retire_payload_o, retire_data_o, count_o); end
    end
    stall = 0; tick();
    vectors++; if (retire_valid_o !== 1'b1 || retire_payload_o !== 160'h200 || retire_data_o !== 32'h00000200 || count_o !== 2'd0) begin miscompares++; $display("FAIL stall_release got v=%b p=%h d=%h cnt=%0d exp 1/200/200/0", retire_valid_o, retire_payload_o, retire_data_o, count_o); end
    tick();
  endtask

  task automatic test_flush();
    iv = 1; iu = 1'(UNIT_XALU); ip = 160'h1F; tick();
    iu = 1'(UNIT_SALU); ip = 160'h2F; tick();
    flush = 1; ud = 2'b01; ur = {32'h0, 32'hDEAD0001}; iu = 1'(UNIT_XALU);
    #1;
    vectors++; if (unit_start_o !== 2'b00 || issue_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_no_start got start=%b rdy=%b exp 00/0", unit_start_o, issue_ready_o); end
    tick(); flush = 0; ud = 2'b00; iv = 0;
    vectors++; if (count_o !== 2'd0 || retire_valid_o !== 1'b0 || unit_pending_o !== 2'b00 || err_o !== 1'b0) begin miscompares++; $display("FAIL flush_clear got cnt=%0d v=%b pend=%b err=%b exp 0/0/00/0", count_o, retire_valid_o, unit_pending_o, err_o); end
    vectors++; if (retire_payload_o !== 160'h0 || retire_data_o !== 32'h0) begin miscompares++; $display("FAIL flush_zero got p=%h d=%h exp 0/0", retire_payload_o, retire_data_o); end
    iv = 1; iu = 1'(UNIT_XALU); ip = 160'h3F;
    #1;
    vectors++; if (issue_ready_o !== 1'b1 || unit_start_o !== 2'b01) begin miscompares++; $display("FAIL flush_reissue got rdy=%b start=%b exp 1/01", issue_ready_o, unit_start_o); end
    tick(); iv = 0;
    ud = 2'b01; ur = {32'h0, 32'h0000003F}; tick(); ud = 2'b00;
    vectors++; if (retire_payload_o !== 160'h3F || count_o !== 2'd0) begin miscompares++; $display("FAIL flush_after got p=%h cnt=%0d exp 3f/0", retire_payload_o, count_o); end
    tick();
  endtask

  task automatic test_error();
    iv = 1; iu = 1'(UNIT_XALU); ip = 160'h55; tick(); iv = 0;
    ud = 2'b10; ur = {32'hBAD0BAD0, 32'h0}; tick(); ud = 2'b00;
    vectors++; if (err_o !== 1'b1 || count_o !== 2'd1 || unit_pending_o !== 2'b01 || retire_valid_o !== 1'b0) begin miscompares++; $display("FAIL err_set got err=%b cnt=%0d pend=%b v=%b exp 1/1/01/0", err_o, count_o, unit_pending_o, retire_valid_o); end
    ud = 2'b01; ur = {32'h0, 32'h00000055}; tick(); ud = 2'b00;
    tick(); tick();
    vectors++; if (err_o !== 1'b1 || count_o !== 2'd0) begin miscompares++; $display("FAIL err_sticky got err=%b cnt=%0d exp 1/0", err_o, count_o); end
    reset = 1; tick(); reset = 0;
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_reset got=%b exp=0", err_o); end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] exp_start;
    for (int c = 0; c < 600; c++) begin
      iv    = ($urandom_range(0, 1) == 1);
      iu    = 1'($urandom_range(0, 1));
      ip    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 39) == 0);
      ur    = {$urandom(), $urandom()};
      ud    = 2'b00;
      for (int u = 0; u < 2; u++) if (m_waiting(u) && $urandom_range(0, 2) == 0) ud[u] = 1'b1;
      #1;
      exp_start = (iv && m_ready()) ? (2'b01 << iu) : 2'b00;
      vectors++; if (issue_ready_o !== m_ready()) begin miscompares++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, issue_ready_o, m_ready()); end
      vectors++; if (unit_start_o !== exp_start) begin miscompares++; $display("FAIL rnd_start[%0d] got=%b exp=%b", c, unit_start_o, exp_start); end
      tick();
      vectors++; if (retire_valid_o !== m_rv) begin miscompares++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, retire_valid_o, m_rv); end
      if (m_rv) begin
        vectors++; if (retire_payload_o !== m_rp || retire_data_o !== m_rd) begin miscompares++; $display("FAIL rnd_retire[%0d] got p=%h d=%h exp p=%h d=%h", c, retire_payload_o, retire_data_o, m_rp, m_rd); end
      end
      vectors++; if (count_o !== 2'(mq.size()) || busy_o !== (mq.size() != 0)) begin miscompares++; $display("FAIL rnd_count[%0d] got cnt=%0d busy=%b exp cnt=%0d", c, count_o, busy_o, mq.size()); end
      vectors++; if (unit_pending_o !== m_pend_mask() || err_o !== m_err) begin miscompares++; $display("FAIL rnd_pend[%0d] got pend=%b err=%b exp pend=%b err=%b", c, unit_pending_o, err_o, m_pend_mask(), m_err); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    m_rv = 0; m_rp = '0; m_rd = '0; m_err = 0;
    test_reset();
    test_basic();
    test_order();
    test_full();
    test_stall();
    test_flush();
    test_error();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/e_longop_retire_queue.md
Name: e_longop_retire_queue

Overview:
- Parametrised parking/retire buffer for the execute stage. Holds long-latency ops (mul, div, clo/clz, future units) while their functional units compute, and merges each unit's result into the parked pipeline payload.
- Retires ops in issue order into the E/M boundary, honours memory-stage stall, and drops everything on exception flush.
- Generalises the single parked-slot-per-unit scheme to NUM_UNITS units and DEPTH in-flight ops.

Parameters:
NUM_UNITS, 2, number of non-pipelined long-latency units (index 0 = XALU, 1 = SALU)
DEPTH, 2, in-flight entries; power of two, >=2
PAYLOAD_W, 160, width of parked pipeline payload (PC, EPC, regid, T, exception flags, instr bus...)
DATA_W, 32, unit result width

Ports:
Clk  in  1  clock
reset  in  1  synchronous, active-high
flush_i  in  1  ExceptionFlush | E_CurrentException; kills all entries
issue_valid_i  in  1  D-stage presents a long op
issue_unit_i  in  $clog2(NUM_UNITS)  target unit index
issue_payload_i  in  PAYLOAD_W  payload captured at issue
issue_ready_o  out  1  issue accepted this cycle when high with issue_valid_i
unit_start_o  out  NUM_UNITS  one-hot start pulse to the selected unit, same cycle as accept
unit_done_i  in  NUM_UNITS  single-cycle completion pulse per unit
unit_result_i  in  NUM_UNITS*DATA_W  result of unit u at bits [u*DATA_W +: DATA_W]
retire_stall_i  in  1  dm_stall; hold retire outputs
retire_valid_o  out  1  registered; retire_payload_o/retire_data_o valid
retire_payload_o  out  PAYLOAD_W  registered payload of retired op
retire_data_o  out  DATA_W  registered unit result
busy_o  out  1  any entry valid (stall feed to hazard unit)
count_o  out  $clog2(DEPTH)+1  valid entries
unit_pending_o  out  NUM_UNITS  unit u has an outstanding entry
err_o  out  1  sticky: done pulse for unit with no pending entry

Behaviour:
- Reset: all entries invalid, head = tail = 0, count_o = 0, unit_pending_o = 0, retire_valid_o = 0, retire_payload_o = 0, retire_data_o = 0, err_o = 0. Outputs unit_start_o = 0 and issue_ready_o = 0 during reset.
- Storage: circular FIFO with head/tail pointers of width $clog2(DEPTH)+1 (extra wrap bit). Full when pointers differ only in the MSB; empty when equal.
- Each entry holds: valid, unit idx, payload, done flag, result.
- Issue accept = issue_valid_i & !full & !unit_pending_o[issue_unit_i] & !flush_i & !reset.
  - The unit is non-pipelined, so at most one outstanding op per unit.
  - On accept: write the entry at tail, tail++, set unit_pending[u], and pulse unit_start_o[u] combinationally.
- Full blocks issue even if a retire happens in the same cycle; no same-cycle slot reuse.
- Completion capture: on unit_done_i[u], find the entry with valid & unit==u & !done, set done, store the result.
  - At most one match is guaranteed by the pending rule.
  - Several units may complete in the same cycle; all are captured.
  - If no pending entry matches: ignore the pulse and set err_o.
- Retire, evaluated when !retire_stall_i:
  - Head is ready if head.done, or if unit_done_i[head.unit] is high this cycle (bypass; result taken from unit_result_i).
  - If ready: load the retire registers, set retire_valid_o = 1, invalidate head, head++, clear unit_pending[head.unit].
  - If not ready: retire_valid_o <= 0 (bubble).
- Latency: done pulse at edge-cycle N on the head entry -> retire_valid_o high after edge N+1 (single cycle), given no stall.
- With retire_stall_i high: retire registers hold value and valid; entries are untouched, but completions are still captured.
- Retire order is strictly issue order. A younger op that completes first waits (done=1) until it becomes head.
- Same-cycle issue to unit u and retire of unit u's entry: issue is still blocked, because pending clears at the edge. unit_pending_o is registered.
- flush_i has priority over everything except reset:
  - Clears entries, pointers, unit_pending_o, and retire_valid_o.
  - retire_payload_o/retire_data_o go to 0.
  - Done pulses in the flush cycle are discarded without setting err_o.
  - No start pulse is issued.
  - Units are flushed separately by the same signal.
- err_o is cleared only by reset.
- busy_o = count_o != 0, where count_o = tail - head.

Decomposition:
- Package e_longop_pkg:
  - entry_t struct (valid, unit, done, result, payload, all parameter-sized via typedef in the module);
  - UNIT_XALU = 0, UNIT_SALU = 1 constants;
  - ptr width function.
- One natural sub-module, e_longop_slot: a single entry register with issue-write, done-capture match, and invalidate. Generated DEPTH times.
- Pointer, arbitration, and retire register stay in the top.

Test Plan:
1. Issue unit0 payload 0xA5; done0 pulse 3 cycles later with result 0x12345678 -> unit_start_o = 01 in the accept cycle; retire_valid_o = 1 exactly one edge after done, retire_data_o = 0x12345678, count_o returns to 0.
2. Issue unit0 (P1) then unit1 (P2); done1 fires 2 cycles before done0 -> P1 retires first, P2 the following cycle; no bubble between them.
3. Fill DEPTH=2, then present a third issue to unit0 while unit0 is pending -> issue_ready_o = 0 until the unit0 entry retires and the next cycle passes.
4. Head done while retire_stall_i is held 4 cycles -> retire outputs frozen during the stall; retire occurs on the first unstalled edge and count_o decrements once.
5. Two entries in flight; assert flush_i in the same cycle as done0 -> count_o = 0, retire_valid_o = 0, err_o stays 0; a new issue the next cycle is accepted.
6. Pulse done1 with no pending entry -> err_o = 1 and remains high until reset; queue state unchanged.
